// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets one of three byte-stream requesters own a UART transmitter
// for a whole packet, with a FETCH-state idle timeout that abandons stalled packets.
module uart_tx_arbiter #(
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req_valid,
    input  logic [23:0] req_data,
    input  logic [2:0]  req_last,
    output logic [2:0]  req_ready,
    input  logic        busy,
    output logic        new_data_tx,
    output logic [7:0]  data_tx,
    output logic [2:0]  grant,
    output logic        timeout_err
);

    typedef enum logic [1:0] {StIdle, StFetch, StSend, StGuard} state_e;

    localparam logic [15:0] CntMax = 16'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [2:0]  grant_q, grant_d;
    logic [1:0]  last_q, last_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  hold_q, hold_d;
    logic        eop_q, eop_d;
    logic        strobe_q, strobe_d;
    logic [7:0]  data_q, data_d;
    logic        to_q, to_d;

    logic [1:0]  gidx;
    logic [1:0]  winner;
    logic [7:0]  sel_data;
    logic        sel_last;
    logic        xfer;

    // Search starts just after the previous owner so it gets lowest priority.
    function automatic logic [1:0] rr_pick(input logic [2:0] valid, input logic [1:0] last);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = 2'd0;
        found = 1'b0;
        idx   = (last == 2'd2) ? 2'd0 : last + 2'd1;
        for (int i = 0; i < 3; i++) begin
            if (!found && valid[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
            idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
        end
        return pick;
    endfunction

    always_comb begin
        case (grant_q)
            3'b010:  gidx = 2'd1;
            3'b100:  gidx = 2'd2;
            default: gidx = 2'd0;
        endcase
    end

    always_comb begin
        case (gidx)
            2'd1:    sel_data = req_data[15:8];
            2'd2:    sel_data = req_data[23:16];
            default: sel_data = req_data[7:0];
        endcase
    end

    assign sel_last  = req_last[gidx];
    assign winner    = rr_pick(req_valid, last_q);
    assign req_ready = (state_q == StFetch) ? grant_q : 3'b000;
    assign xfer      = |(req_valid & req_ready);

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        hold_d   = hold_q;
        eop_d    = eop_q;
        strobe_d = 1'b0;
        data_d   = data_q;
        to_d     = 1'b0;
        case (state_q)
            StIdle: begin
                grant_d = 3'b000;
                if (|req_valid) begin
                    grant_d = 3'b001 << winner;
                    cnt_d   = 16'd0;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (xfer) begin
                    hold_d  = sel_data;
                    eop_d   = sel_last;
                    state_d = StSend;
                end else if (cnt_q == CntMax) begin
                    grant_d = 3'b000;
                    last_d  = gidx;
                    to_d    = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StSend: begin
                if (!busy) begin
                    strobe_d = 1'b1;
                    data_d   = hold_q;
                    state_d  = StGuard;
                end
            end
            StGuard: begin
                // busy is not yet valid for the byte just strobed, so it is not looked at here.
                if (eop_q) begin
                    grant_d = 3'b000;
                    last_d  = gidx;
                    state_d = StIdle;
                end else begin
                    cnt_d   = 16'd0;
                    state_d = StFetch;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            grant_q  <= 3'b000;
            last_q   <= 2'd2;
            cnt_q    <= 16'd0;
            hold_q   <= 8'h00;
            eop_q    <= 1'b0;
            strobe_q <= 1'b0;
            data_q   <= 8'h00;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            hold_q   <= hold_d;
            eop_q    <= eop_d;
            strobe_q <= strobe_d;
            data_q   <= data_d;
            to_q     <= to_d;
        end
    end

    assign grant       = grant_q;
    assign new_data_tx = strobe_q;
    assign data_tx     = data_q;
    assign timeout_err = to_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-requester byte queues feed the DUT, strobes are logged
// and each scenario task compares the log and outputs against hand-derived values.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req_valid;
    logic [23:0] req_data;
    logic [2:0]  req_last;
    logic [2:0]  req_ready;
    logic        busy;
    logic        new_data_tx;
    logic [7:0]  data_tx;
    logic [2:0]  grant;
    logic        timeout_err;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.TIMEOUT(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .busy        (busy),
        .new_data_tx (new_data_tx),
        .data_tx     (data_tx),
        .grant       (grant),
        .timeout_err (timeout_err)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int dbl_cnt;
    int to_cnt;
    int to_cyc;
    logic prev_strobe;

    // Each entry is {last, data}.
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [8:0] q2[$];

    logic [7:0] log_data[$];
    logic [2:0] log_grant[$];
    int         log_cyc[$];

    task automatic drive();
        req_valid = {q2.size() > 0, q1.size() > 0, q0.size() > 0};
        req_data  = 24'h0;
        req_last  = 3'b000;
        if (q0.size() > 0) begin req_data[7:0]   = q0[0][7:0]; req_last[0] = q0[0][8]; end
        if (q1.size() > 0) begin req_data[15:8]  = q1[0][7:0]; req_last[1] = q1[0][8]; end
        if (q2.size() > 0) begin req_data[23:16] = q2[0][7:0]; req_last[2] = q2[0][8]; end
    endtask

    // Advance one clock: sample handshakes mid-cycle, pop accepted bytes, log outputs after edge.
    task automatic step();
        logic [2:0] fire;
        #4;
        fire = req_valid & req_ready;
        @(posedge clk);
        #1;
        cyc++;
        if (fire[0]) void'(q0.pop_front());
        if (fire[1]) void'(q1.pop_front());
        if (fire[2]) void'(q2.pop_front());
        drive();
        if (new_data_tx) begin
            log_data.push_back(data_tx);
            log_grant.push_back(grant);
            log_cyc.push_back(cyc);
            if (prev_strobe) dbl_cnt++;
        end
        prev_strobe = new_data_tx;
        if (timeout_err) begin
            to_cnt++;
            to_cyc = cyc;
        end
    endtask

    task automatic clear_log();
        log_data.delete();
        log_grant.delete();
        log_cyc.delete();
        dbl_cnt     = 0;
        to_cnt      = 0;
        to_cyc      = -1;
        prev_strobe = 1'b0;
    endtask

    task automatic do_reset();
        rst  = 1'b0;
        busy = 1'b0;
        q0.delete();
        q1.delete();
        q2.delete();
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        clear_log();
    endtask

    task automatic test_reset();
        rst  = 1'b0;
        busy = 1'b0;
        q0.delete();
        q1.delete();
        q2.delete();
        q0.push_back(9'h1AA);
        drive();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (grant !== 3'b000) begin errors++; $display("FAIL reset_grant: got %b want 000", grant); end
        checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL reset_ready: got %b want 000", req_ready); end
        checks++; if (new_data_tx !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b want 0", new_data_tx); end
        checks++; if (data_tx !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data_tx); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout_err); end
        q0.delete();
        drive();
        rst = 1'b1;
        clear_log();
    endtask

    task automatic test_single();
        do_reset();
        q0.push_back({1'b1, 8'h41});
        drive();
        step();  // IDLE samples valid
        checks++; if (grant !== 3'b001) begin errors++; $display("FAIL single_grant: got %b want 001", grant); end
        checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL single_ready: got %b want 001", req_ready); end
        step();  // byte accepted
        checks++; if (new_data_tx !== 1'b0) begin errors++; $display("FAIL single_early: got %b want 0", new_data_tx); end
        checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL single_ready_send: got %b want 000", req_ready); end
        step();  // third edge: strobe
        checks++; if (new_data_tx !== 1'b1) begin errors++; $display("FAIL single_strobe: got %b want 1", new_data_tx); end
        checks++; if (data_tx !== 8'h41) begin errors++; $display("FAIL single_data: got %h want 41", data_tx); end
        step();
        checks++; if (grant !== 3'b000) begin errors++; $display("FAIL single_release: got %b want 000", grant); end
        checks++; if (new_data_tx !== 1'b0 || data_tx !== 8'h41) begin
            errors++; $display("FAIL single_hold: got strobe %b data %h want 0 41", new_data_tx, data_tx);
        end
        repeat (4) step();
        checks++; if (log_data.size() != 1) begin errors++; $display("FAIL single_count: got %0d want 1", log_data.size()); end
    endtask

    task automatic test_contention();
        logic [7:0] exp_d [6];
        logic [2:0] exp_g [6];
        exp_d = '{8'h10, 8'h20, 8'h30, 8'h11, 8'h21, 8'h31};
        exp_g = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        do_reset();
        q0.push_back({1'b1, 8'h10}); q0.push_back({1'b1, 8'h11});
        q1.push_back({1'b1, 8'h20}); q1.push_back({1'b1, 8'h21});
        q2.push_back({1'b1, 8'h30}); q2.push_back({1'b1, 8'h31});
        drive();
        repeat (40) step();
        checks++; if (log_data.size() != 6) begin errors++; $display("FAIL cont_count: got %0d want 6", log_data.size()); end
        for (int i = 0; i < 6 && i < log_data.size(); i++) begin
            checks++;
            if (log_data[i] !== exp_d[i] || log_grant[i] !== exp_g[i]) begin
                errors++;
                $display("FAIL cont_order[%0d]: got %h/%b want %h/%b", i, log_data[i], log_grant[i],
                         exp_d[i], exp_g[i]);
            end
        end
        checks++; if (dbl_cnt != 0) begin errors++; $display("FAIL cont_overlap: got %0d want 0", dbl_cnt); end
    endtask

    task automatic test_packet_lock();
        logic [7:0] exp_d [4];
        logic [2:0] exp_g [4];
        exp_d = '{8'hA0, 8'hA1, 8'hA2, 8'h50};
        exp_g = '{3'b010, 3'b010, 3'b010, 3'b001};
        do_reset();
        q1.push_back({1'b0, 8'hA0}); q1.push_back({1'b0, 8'hA1}); q1.push_back({1'b1, 8'hA2});
        drive();
        step();
        q0.push_back({1'b1, 8'h50});
        drive();
        repeat (30) step();
        checks++; if (log_data.size() != 4) begin errors++; $display("FAIL lock_count: got %0d want 4", log_data.size()); end
        for (int i = 0; i < 4 && i < log_data.size(); i++) begin
            checks++;
            if (log_data[i] !== exp_d[i] || log_grant[i] !== exp_g[i]) begin
                errors++;
                $display("FAIL lock_order[%0d]: got %h/%b want %h/%b", i, log_data[i], log_grant[i],
                         exp_d[i], exp_g[i]);
            end
        end
        if (log_cyc.size() >= 2) begin
            checks++;
            if (log_cyc[1] - log_cyc[0] != 3) begin
                errors++; $display("FAIL lock_spacing: got %0d want 3", log_cyc[1] - log_cyc[0]);
            end
        end
    endtask

    task automatic test_busy_stall();
        do_reset();
        busy = 1'b1;
        q0.push_back({1'b1, 8'h77});
        drive();
        step();
        step();  // now in SEND
        repeat (50) step();
        checks++; if (log_data.size() != 0) begin errors++; $display("FAIL stall_strobe: got %0d want 0", log_data.size()); end
        checks++; if (to_cnt != 0) begin errors++; $display("FAIL stall_timeout: got %0d want 0", to_cnt); end
        busy = 1'b0;
        step();
        checks++; if (new_data_tx !== 1'b1 || data_tx !== 8'h77) begin
            errors++; $display("FAIL stall_release: got %b/%h want 1/77", new_data_tx, data_tx);
        end
        busy = 1'b1;  // ignored during the guard cycle
        step();
        checks++; if (new_data_tx !== 1'b0 || grant !== 3'b000) begin
            errors++; $display("FAIL stall_after: got %b/%b want 0/000", new_data_tx, grant);
        end
        busy = 1'b0;
        repeat (5) step();
        checks++; if (log_data.size() != 1) begin errors++; $display("FAIL stall_count: got %0d want 1", log_data.size()); end
    endtask

    task automatic test_timeout();
        int start;
        do_reset();
        q2.push_back({1'b0, 8'h5A});
        drive();
        start = cyc;
        repeat (20) step();
        checks++; if (to_cnt != 1) begin errors++; $display("FAIL to_pulses: got %0d want 1", to_cnt); end
        // FETCH re-entered at start+4; the pulse appears 8 cycles later.
        checks++; if (to_cyc != start + 12) begin errors++; $display("FAIL to_time: got %0d want %0d", to_cyc, start + 12); end
        checks++; if (grant !== 3'b000) begin errors++; $display("FAIL to_grant: got %b want 000", grant); end
        checks++; if (log_data.size() != 1) begin errors++; $display("FAIL to_bytes: got %0d want 1", log_data.size()); end
        clear_log();
        q1.push_back({1'b1, 8'h61});
        q2.push_back({1'b1, 8'h62});
        q0.push_back({1'b1, 8'h60});
        drive();
        repeat (20) step();
        checks++; if (log_grant.size() < 1 || log_grant[0] !== 3'b001) begin
            errors++; $display("FAIL to_next: got %0d strobes first %b want 001", log_grant.size(),
                               (log_grant.size() > 0) ? log_grant[0] : 3'bxxx);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        busy = 1'b1;
        q0.push_back({1'b1, 8'h99});
        drive();
        step();
        step();  // in SEND, stalled
        #2;
        rst = 1'b0;
        #1;
        checks++; if (grant !== 3'b000 || req_ready !== 3'b000) begin
            errors++; $display("FAIL mid_grant: got %b/%b want 000/000", grant, req_ready);
        end
        checks++; if (new_data_tx !== 1'b0 || data_tx !== 8'h00) begin
            errors++; $display("FAIL mid_out: got %b/%h want 0/00", new_data_tx, data_tx);
        end
        busy = 1'b0;
        @(posedge clk);
        #1;
        repeat (3) step();
        rst = 1'b1;
        q1.push_back({1'b1, 8'h02});
        q0.push_back({1'b1, 8'h01});
        drive();
        repeat (20) step();
        checks++; if (log_data.size() != 2) begin errors++; $display("FAIL mid_count: got %0d want 2", log_data.size()); end
        if (log_data.size() >= 1) begin
            checks++;
            if (log_data[0] !== 8'h01 || log_grant[0] !== 3'b001) begin
                errors++; $display("FAIL mid_first: got %h/%b want 01/001", log_data[0], log_grant[0]);
            end
        end
    endtask

    initial begin
        rst       = 1'b0;
        busy      = 1'b0;
        req_valid = 3'b000;
        req_data  = 24'h0;
        req_last  = 3'b000;
        clear_log();
        #1;
        test_reset();
        test_single();
        test_contention();
        test_packet_lock();
        test_busy_stall();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1000, giving the FETCH-state idle limit in clock cycles (legal range 1..65535).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port req_valid, input, 3, per-requester byte-valid; bit i belongs to requester i.
REQ-005 SHALL have port req_data, input, 24, per-requester byte; requester i drives bits [8i+7:8i].
REQ-006 SHALL have port req_last, input, 3, per-requester end-of-packet flag, qualified by req_valid.
REQ-007 SHALL have port req_ready, output, 3, per-requester byte-accept; a byte transfers on any edge where req_valid[i] and req_ready[i] are both high.
REQ-008 SHALL have port busy, input, 1, serial transmitter busy.
REQ-009 SHALL have port new_data_tx, output, 1, one-cycle transmit strobe to the serial transmitter.
REQ-010 SHALL have port data_tx, output, 8, byte to the transmitter, valid while new_data_tx is high.
REQ-011 SHALL have port grant, output, 3, one-hot owner of the transmitter; all-zero when no owner.
REQ-012 SHALL have port timeout_err, output, 1, one-cycle pulse when a packet is aborted by timeout.

Function
REQ-013 SHALL implement states IDLE, FETCH, SEND and GUARD.
REQ-014 In IDLE with any req_valid high, SHALL select the winner round-robin, searching from (last+1) mod 3 upward with wrap; SHALL set grant one-hot to the winner; SHALL clear the timeout counter; SHALL go to FETCH.
REQ-015 In IDLE with no req_valid high, SHALL remain in IDLE with grant = 0.
REQ-016 req_ready SHALL equal grant while in FETCH and SHALL be 0 in every other state (combinational decode of state and grant).
REQ-017 In FETCH, on a transfer, SHALL latch the granted byte into a hold register, latch req_last of the granted requester, and go to SEND.
REQ-018 In FETCH without a transfer, SHALL increment the timeout counter. At count TIMEOUT-1 it SHALL clear grant, set last to the granted index, pulse timeout_err for one cycle, and go to IDLE.
REQ-019 In SEND with busy low, SHALL register new_data_tx = 1 and data_tx = hold, and go to GUARD.
REQ-020 In SEND with busy high, SHALL wait indefinitely; there is no timeout in SEND.
REQ-021 In GUARD, SHALL drive new_data_tx to 0 and SHALL ignore busy for that cycle, covering the transmitter's one-cycle busy latency.
REQ-022 On leaving GUARD with the latched last flag set, SHALL clear grant, set last to the granted index, and go to IDLE. Otherwise it SHALL clear the timeout counter and return to FETCH.
REQ-023 grant SHALL stay constant from the first byte of a packet through its last byte; req_valid from non-granted requesters SHALL be ignored for the whole packet.
REQ-024 data_tx SHALL hold its last value after the strobe.
REQ-025 new_data_tx SHALL never be high on two consecutive cycles.
REQ-026 Latency: with busy low, new_data_tx SHALL be high in the cycle following the third edge counted from the edge at which IDLE samples req_valid. Each later byte of the same packet, given immediate req_valid, SHALL follow 3 cycles after the previous strobe.
REQ-027 A requester that has just finished a packet SHALL have lowest priority in the next arbitration.

Reset
REQ-028 While rst is low: state = IDLE, new_data_tx = 0, data_tx = 8'h00, grant = 0, req_ready = 0, timeout_err = 0, timeout counter = 0, last = 2 (requester 0 has first priority).
REQ-029 Reset asserted mid-packet SHALL abandon the packet with no further strobe.
REQ-030 After reset deasserts, arbitration SHALL restart from IDLE.

Verification
REQ-031 Single byte: requester 0 sends 8'h41 with req_last = 1, busy = 0 -> one new_data_tx pulse with data_tx = 8'h41, 3 edges after IDLE samples valid; grant returns to 0.
REQ-032 Contention: all three requesters send 1-byte packets continuously -> grant order 0,1,2,0,1,2; no strobe overlaps.
REQ-033 Packet lock: requester 1 sends 8'hA0, 8'hA1, 8'hA2 (last on A2) while requester 0 is valid -> bytes A0, A1, A2 go out contiguously before any requester-0 byte.
REQ-034 Busy stall: busy held high for 50 cycles in SEND -> no strobe during the stall; exactly one strobe in the cycle after busy falls.
REQ-035 Timeout: TIMEOUT = 8; requester 2 sends one non-last byte then drops valid -> timeout_err pulses once, 8 cycles after FETCH entry; grant = 0; next winner is requester 0.
REQ-036 Reset mid-packet: rst low during SEND -> all outputs reset immediately; no strobe; after release, requester 0 wins first.
